// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - format/flag codes and per-format geometry shared by the sqrt input stage
package sqrt_pkg;

   typedef enum logic [1:0] {
      FMT_HALF   = 2'b00,
      FMT_SINGLE = 2'b01,
      FMT_DOUBLE = 2'b10,
      FMT_RSVD   = 2'b11
   } fmt_e;

   typedef enum logic [2:0] {
      FLG_DENORM   = 3'b000,
      FLG_ZERO     = 3'b001,
      FLG_INF      = 3'b010,
      FLG_NAN      = 3'b011,
      FLG_NORMAL   = 3'b100,
      FLG_SIGN_ERR = 3'b111
   } flg_e;

   localparam int unsigned HALF_M      = 11;
   localparam int unsigned HALF_E      = 5;
   localparam int unsigned HALF_BIAS   = 15;
   localparam int unsigned SINGLE_M    = 24;
   localparam int unsigned SINGLE_E    = 8;
   localparam int unsigned SINGLE_BIAS = 127;
   localparam int unsigned DOUBLE_M    = 53;
   localparam int unsigned DOUBLE_E    = 11;
   localparam int unsigned DOUBLE_BIAS = 1023;

   // Reserved format falls back to double geometry; its flags force NaN anyway.
   function automatic int unsigned fmt_man_w(input logic [1:0] fmt);
      case (fmt)
         FMT_HALF:   return HALF_M;
         FMT_SINGLE: return SINGLE_M;
         default:    return DOUBLE_M;
      endcase
   endfunction

   function automatic int unsigned fmt_exp_w(input logic [1:0] fmt);
      case (fmt)
         FMT_HALF:   return HALF_E;
         FMT_SINGLE: return SINGLE_E;
         default:    return DOUBLE_E;
      endcase
   endfunction

   function automatic int unsigned fmt_bias(input logic [1:0] fmt);
      case (fmt)
         FMT_HALF:   return HALF_BIAS;
         FMT_SINGLE: return SINGLE_BIAS;
         default:    return DOUBLE_BIAS;
      endcase
   endfunction

endpackage

// File: rtl/sqrt_operand_prep.sv
// rtl/sqrt_operand_prep.sv - combinational flag resolution, radicand alignment and exponent halving
module sqrt_operand_prep
   import sqrt_pkg::*;
#(
   parameter int MAN_W = 53,
   parameter int EXP_W = 11,
   parameter int OUT_W = 2 * MAN_W
) (
   input  logic [1:0]       op_fmt,
   input  logic             op_sign,
   input  logic [EXP_W-1:0] op_exp,
   input  logic [MAN_W-1:0] op_mantisa,
   input  logic [2:0]       op_flags,
   output logic [EXP_W-1:0] prep_exp,
   output logic [OUT_W-1:0] prep_mantisa,
   output logic [2:0]       prep_flags,
   output logic             prep_run
);

   int unsigned      m_w;
   int unsigned      e_w;
   int unsigned      bias;
   logic [OUT_W-1:0] man_mask;
   logic [OUT_W-1:0] justified;
   logic [EXP_W-1:0] exp_mask;
   logic [EXP_W:0]   exp_sum;

   always_comb begin
      m_w  = fmt_man_w(op_fmt);
      e_w  = fmt_exp_w(op_fmt);
      bias = fmt_bias(op_fmt);

      // -0 keeps its zero flag: sqrt(-0) is -0, not a sign error.
      if (op_fmt == FMT_RSVD)        prep_flags = FLG_NAN;
      else if (op_flags == FLG_ZERO) prep_flags = FLG_ZERO;
      else if (op_flags == FLG_NAN)  prep_flags = FLG_NAN;
      else if (op_sign)              prep_flags = FLG_SIGN_ERR;
      else                           prep_flags = op_flags;

      prep_run = (prep_flags == FLG_NORMAL);

      // Odd biased exponent drops the radicand one place so the root exponent halves exactly.
      man_mask  = {OUT_W{1'b1}} >> (OUT_W - m_w);
      justified = ((OUT_W'(op_mantisa) & man_mask) << (OUT_W - m_w)) >> op_exp[0];

      exp_mask = {EXP_W{1'b1}} >> (EXP_W - e_w);
      exp_sum  = {1'b0, op_exp & exp_mask} + (EXP_W + 1)'(bias);

      prep_mantisa = prep_run ? justified : '0;
      prep_exp     = prep_run ? exp_sum[EXP_W:1] : '0;
   end

endmodule

// File: rtl/sqrt_input_stage.sv
// rtl/sqrt_input_stage.sv - buffered operand input stage: prepares operands and queues them in a FIFO
module sqrt_input_stage
   import sqrt_pkg::*;
#(
   parameter int MAN_W = 53,
   parameter int EXP_W = 11,
   parameter int OUT_W = 2 * MAN_W,
   parameter int TAG_W = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_fmt,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [MAN_W-1:0] in_mantisa,
   input  logic [2:0]       in_flags,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_fmt,
   output logic [EXP_W-1:0] out_exp,
   output logic [OUT_W-1:0] out_mantisa,
   output logic [2:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_run
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [EXP_W-1:0] p_exp;
   logic [OUT_W-1:0] p_mantisa;
   logic [2:0]       p_flags;
   logic             p_run;

   sqrt_operand_prep #(
      .MAN_W(MAN_W),
      .EXP_W(EXP_W),
      .OUT_W(OUT_W)
   ) u_prep (
      .op_fmt      (in_fmt),
      .op_sign     (in_sign),
      .op_exp      (in_exp),
      .op_mantisa  (in_mantisa),
      .op_flags    (in_flags),
      .prep_exp    (p_exp),
      .prep_mantisa(p_mantisa),
      .prep_flags  (p_flags),
      .prep_run    (p_run)
   );

   logic [1:0]       fmt_mem  [DEPTH];
   logic [EXP_W-1:0] exp_mem  [DEPTH];
   logic [OUT_W-1:0] man_mem  [DEPTH];
   logic [2:0]       flg_mem  [DEPTH];
   logic [TAG_W-1:0] tag_mem  [DEPTH];
   logic             run_mem  [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          started;
   logic          push;
   logic          pop;

   // started keeps in_ready low until the first edge after reset release.
   assign in_ready  = started && (count < FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         started <= 1'b0;
      end else begin
         started <= 1'b1;
         if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fmt_mem[wr_ptr] <= in_fmt;
         exp_mem[wr_ptr] <= p_exp;
         man_mem[wr_ptr] <= p_mantisa;
         flg_mem[wr_ptr] <= p_flags;
         tag_mem[wr_ptr] <= in_tag;
         run_mem[wr_ptr] <= p_run;
      end
   end

   // Shadow of the last presented head so outputs hold their values while empty.
   logic [1:0]       hold_fmt;
   logic [EXP_W-1:0] hold_exp;
   logic [OUT_W-1:0] hold_man;
   logic [2:0]       hold_flg;
   logic [TAG_W-1:0] hold_tag;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_fmt <= '0;
         hold_exp <= '0;
         hold_man <= '0;
         hold_flg <= '0;
         hold_tag <= '0;
      end else if (out_valid) begin
         hold_fmt <= fmt_mem[rd_ptr];
         hold_exp <= exp_mem[rd_ptr];
         hold_man <= man_mem[rd_ptr];
         hold_flg <= flg_mem[rd_ptr];
         hold_tag <= tag_mem[rd_ptr];
      end
   end

   assign out_fmt     = out_valid ? fmt_mem[rd_ptr] : hold_fmt;
   assign out_exp     = out_valid ? exp_mem[rd_ptr] : hold_exp;
   assign out_mantisa = out_valid ? man_mem[rd_ptr] : hold_man;
   assign out_flags   = out_valid ? flg_mem[rd_ptr] : hold_flg;
   assign out_tag     = out_valid ? tag_mem[rd_ptr] : hold_tag;
   assign out_run     = out_valid && run_mem[rd_ptr];

endmodule

// File: tb/tb_sqrt_input_stage.sv
// tb/tb_sqrt_input_stage.sv - self-checking bench for sqrt_input_stage
module tb_sqrt_input_stage;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_fmt = '0;
   logic         in_sign = 1'b0;
   logic [10:0]  in_exp = '0;
   logic [52:0]  in_mantisa = '0;
   logic [2:0]   in_flags = '0;
   logic [3:0]   in_tag = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [1:0]   out_fmt;
   logic [10:0]  out_exp;
   logic [105:0] out_mantisa;
   logic [2:0]   out_flags;
   logic [3:0]   out_tag;
   logic         out_run;

   int checks = 0;
   int errors = 0;

   sqrt_input_stage dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_fmt     (in_fmt),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_mantisa (in_mantisa),
      .in_flags   (in_flags),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_fmt    (out_fmt),
      .out_exp    (out_exp),
      .out_mantisa(out_mantisa),
      .out_flags  (out_flags),
      .out_tag    (out_tag),
      .out_run    (out_run)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]   fmt;
      logic [10:0]  exp;
      logic [105:0] man;
      logic [2:0]   flags;
      logic [3:0]   tag;
      logic         run;
   } ent_t;

   ent_t q[$];
   ent_t last = '0;
   bit   started = 1'b0;

   function automatic ent_t model_prep(input logic [1:0] fmt, input logic sign, input logic [10:0] exp,
                                       input logic [52:0] man, input logic [2:0] flags, input logic [3:0] tag);
      ent_t         e;
      int           m, ew, bias;
      logic [105:0] r;
      int           ev;
      e = '0;
      case (fmt)
         2'b00:   begin m = 11; ew = 5;  bias = 15;   end
         2'b01:   begin m = 24; ew = 8;  bias = 127;  end
         default: begin m = 53; ew = 11; bias = 1023; end
      endcase
      if (fmt == 2'b11)        e.flags = 3'b011;
      else if (flags == 3'b001) e.flags = 3'b001;
      else if (flags == 3'b011) e.flags = 3'b011;
      else if (sign)            e.flags = 3'b111;
      else                      e.flags = flags;
      e.run = (e.flags == 3'b100);
      e.fmt = fmt;
      e.tag = tag;
      if (e.run) begin
         r = 106'(man);
         r = r << (106 - m);
         if (exp % 2 == 1) r = r / 2;
         e.man = r;
         ev = (int'(exp) % (1 << ew) + bias) / 2;
         e.exp = 11'(ev);
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         last    = '0;
         started = 1'b0;
      end else begin
         bit acc, pp;
         acc = in_valid && started && (q.size() < 2);
         pp  = (q.size() > 0) && out_ready;
         if (q.size() > 0) last = q[0];
         if (flush) q.delete();
         else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(model_prep(in_fmt, in_sign, in_exp, in_mantisa, in_flags, in_tag));
         end
         started = 1'b1;
      end
   end

   always @(negedge clk) begin
      ent_t e;
      logic exp_ready, exp_valid;
      exp_ready = started && (q.size() < 2);
      exp_valid = (q.size() > 0);
      if (exp_valid) e = q[0];
      else begin
         e = last;
         e.run = 1'b0;
      end
      checks++;
      if ({in_ready, out_valid} !== {exp_ready, exp_valid} ||
          {out_fmt, out_exp, out_mantisa, out_flags, out_tag, out_run} !== e) begin
         errors++;
         $display("FAIL cycle_compare t=%0t actual rdy=%b vld=%b fmt=%0h exp=%0h man=%0h flg=%0h tag=%0h run=%b required rdy=%b vld=%b fmt=%0h exp=%0h man=%0h flg=%0h tag=%0h run=%b",
                  $time, in_ready, out_valid, out_fmt, out_exp, out_mantisa, out_flags, out_tag, out_run,
                  exp_ready, exp_valid, e.fmt, e.exp, e.man, e.flags, e.tag, e.run);
      end
   end

   task automatic lit(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [1:0] fmt, input logic sign, input logic [10:0] exp,
                        input logic [52:0] man, input logic [2:0] flags, input logic [3:0] tag);
      in_valid   = 1'b1;
      in_fmt     = fmt;
      in_sign    = sign;
      in_exp     = exp;
      in_mantisa = man;
      in_flags   = flags;
      in_tag     = tag;
   endtask

   logic [105:0] man_lit;

   initial begin
      repeat (3) step();
      lit("reset_in_ready", 128'(in_ready), 128'd0);
      lit("reset_out_valid", 128'(out_valid), 128'd0);
      lit("reset_out_mantisa", 128'(out_mantisa), 128'd0);
      rst = 1'b1;
      #1;
      lit("ready_low_before_edge", 128'(in_ready), 128'd0);
      step();
      lit("ready_after_release", 128'(in_ready), 128'd1);

      // double, exponent 0x3FF (odd)
      drive(2'b10, 1'b0, 11'h3FF, 53'd1 << 52, 3'b100, 4'd1);
      step();
      in_valid = 1'b0;
      man_lit = '0;
      man_lit[104] = 1'b1;
      lit("dbl_valid", 128'(out_valid), 128'd1);
      lit("dbl_exp", 128'(out_exp), 128'h3FF);
      lit("dbl_man", 128'(out_mantisa), 128'(man_lit));
      lit("dbl_run", 128'(out_run), 128'd1);
      out_ready = 1'b1;
      step();

      // single, exponent 0x80 (even)
      drive(2'b01, 1'b0, 11'h080, 53'hC00000, 3'b100, 4'd2);
      step();
      in_valid = 1'b0;
      lit("sgl_exp", 128'(out_exp), 128'h7F);
      lit("sgl_man_top", 128'(out_mantisa[105:104]), 128'd3);
      lit("sgl_run", 128'(out_run), 128'd1);
      step();

      drive(2'b00, 1'b1, 11'h00F, 53'h400, 3'b100, 4'd3);
      step();
      in_valid = 1'b0;
      lit("half_neg_flags", 128'(out_flags), 128'h7);
      lit("half_neg_run", 128'(out_run), 128'd0);
      step();

      drive(2'b00, 1'b1, 11'h00F, 53'h400, 3'b001, 4'd4);
      step();
      in_valid = 1'b0;
      lit("half_negzero_flags", 128'(out_flags), 128'h1);
      step();

      drive(2'b11, 1'b0, 11'h2A5, 53'h1F_FFFF_1234_5678, 3'b100, 4'd5);
      step();
      in_valid = 1'b0;
      lit("rsvd_flags", 128'(out_flags), 128'h3);
      lit("rsvd_run", 128'(out_run), 128'd0);
      lit("rsvd_man", 128'(out_mantisa), 128'd0);
      lit("rsvd_tag", 128'(out_tag), 128'd5);
      step();
      lit("empty_hold_tag", 128'(out_tag), 128'd5);

      // backpressure: three operands offered, two fit
      out_ready = 1'b0;
      drive(2'b10, 1'b0, 11'h400, 53'h1A_0000_0000_0001, 3'b100, 4'd6);
      step();
      in_tag = 4'd7;
      step();
      in_tag = 4'd8;
      step();
      lit("full_in_ready", 128'(in_ready), 128'd0);
      lit("full_head_tag", 128'(out_tag), 128'd6);
      step();
      lit("stall_head_tag", 128'(out_tag), 128'd6);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      lit("pop_second_tag", 128'(out_tag), 128'd7);
      lit("ready_returns", 128'(in_ready), 128'd1);
      step();
      lit("drained", 128'(out_valid), 128'd0);

      // flush with simultaneous push
      out_ready = 1'b0;
      drive(2'b01, 1'b0, 11'h07F, 53'h800000, 3'b100, 4'd9);
      step();
      flush  = 1'b1;
      in_tag = 4'd10;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      lit("flush_valid", 128'(out_valid), 128'd0);
      step();
      lit("flush_stays_empty", 128'(out_valid), 128'd0);

      // reset in mid-stream
      drive(2'b10, 1'b0, 11'h3FE, 53'h1F_0000_0000_0000, 3'b100, 4'd11);
      step();
      in_tag = 4'd12;
      step();
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      lit("midrst_valid", 128'(out_valid), 128'd0);
      lit("midrst_ready", 128'(in_ready), 128'd0);
      lit("midrst_exp", 128'(out_exp), 128'd0);
      step();
      rst = 1'b1;
      step();
      lit("rst_recover_ready", 128'(in_ready), 128'd1);

      // streaming at full rate with varied operands
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(2'(i % 3), 1'b0, 11'($urandom), 53'({$urandom, $urandom}) | (53'd1 << 52),
               (i % 4 == 3) ? 3'b010 : 3'b100, 4'(i));
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
